// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator and dmem_responder.
//   master : initiator side (drives requests, accepts responses)
//   slave  : responder side (accepts requests, drives responses)
// Signals: req_valid/req_ready handshake carrying write/addr/wstrb/wdata;
//          resp_valid/resp_ready handshake carrying rdata/err.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wstrb, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wstrb, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// A request is accepted in IDLE, held for WAIT cycles, then the memory
// access happens and the response is held in RESP until handshaked.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - dmem_responder_if.slave (request/response handshakes)
//   busy - high whenever the FSM is not in IDLE
module dmem_responder #(
  parameter int IDX_W = 10,
  parameter int WAIT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         DEPTH   = 2**IDX_W;
  localparam logic [3:0] WAIT_C  = 4'(WAIT);
  localparam bit         NO_WAIT = (WAIT == 0);

  state_t      state;
  logic [3:0]  cnt;

  logic        l_write;
  logic [31:0] l_addr;
  logic [3:0]  l_wstrb;
  logic [31:0] l_wdata;

  logic [31:0] mem [DEPTH];

  logic             accept;
  logic             access;
  logic             a_write;
  logic [31:0]      a_addr;
  logic [3:0]       a_wstrb;
  logic [31:0]      a_wdata;
  logic             oor;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;

  assign accept = (state == S_IDLE) && bus.req_valid && bus.req_ready;
  assign access = (accept && NO_WAIT) || (state == S_WAIT && cnt == 4'd1);

  // With no wait states the access happens at the accept edge, so the
  // request comes straight from the bus; otherwise from the latched copy.
  assign a_write = (state == S_IDLE) ? bus.req_write : l_write;
  assign a_addr  = (state == S_IDLE) ? bus.req_addr  : l_addr;
  assign a_wstrb = (state == S_IDLE) ? bus.req_wstrb : l_wstrb;
  assign a_wdata = (state == S_IDLE) ? bus.req_wdata : l_wdata;

  // Any set bit above the word index is out of range; byte offset ignored.
  assign oor     = (a_addr >> (IDX_W + 2)) != 32'd0;
  assign idx     = a_addr[IDX_W+1:2];
  assign rd_word = (a_write || oor) ? 32'd0 : mem[idx];

  // Memory array is never reset.
  always_ff @(posedge clk) begin
    if (access && a_write && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (a_wstrb[b]) mem[idx][8*b +: 8] <= a_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      busy           <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
      l_write        <= 1'b0;
      l_addr         <= 32'd0;
      l_wstrb        <= 4'd0;
      l_wdata        <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.req_ready <= 1'b1;
          if (accept) begin
            l_write       <= bus.req_write;
            l_addr        <= bus.req_addr;
            l_wstrb       <= bus.req_wstrb;
            l_wdata       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (NO_WAIT) begin
              state          <= S_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= rd_word;
              bus.resp_err   <= oor;
            end else begin
              cnt   <= WAIT_C;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state          <= S_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= rd_word;
            bus.resp_err   <= oor;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state          <= S_IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            busy           <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy2, busy0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.IDX_W(10), .WAIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .busy(busy2));
  dmem_responder #(.IDX_W(10), .WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .busy(busy0));

  // One full transaction on the WAIT=2 instance with resp_ready high.
  // lat counts cycles from the accept edge: 1 = visible right after it.
  task automatic xact2(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int lat,
                       output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_write = w; bus2.req_addr = a;
    bus2.req_wstrb = s; bus2.req_wdata = d; bus2.resp_ready = 1'b1;
    n = 0;
    while (bus2.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", a, bus2.req_ready);
    end
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    lat = 1;
    while (bus2.resp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = bus2.resp_rdata; er = bus2.resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus2.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b required 0", bus2.req_ready); end
    checks++; if (bus2.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b required 0", bus2.resp_valid); end
    checks++; if (bus2.resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h required 0", bus2.resp_rdata); end
    checks++; if (bus2.resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b required 0", bus2.resp_err); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy2); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus2.req_ready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready got %b required 1", bus2.req_ready); end
    checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready0 got %b required 1", bus0.req_ready); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er;
    xact2(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, lat, rd, er);
    checks++; if (lat != 3) begin errors++; $display("FAIL store_latency got %0d required 3", lat); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL store_resp got rd=%h err=%b required 0/0", rd, er); end
    xact2(1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, er);
    checks++; if (lat != 3) begin errors++; $display("FAIL load_latency got %0d required 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_data got rd=%h err=%b required deadbeef/0", rd, er); end
    // low address bits ignored
    xact2(1'b0, 32'h13, 4'b0000, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL unaligned_load got rd=%h err=%b required deadbeef/0", rd, er); end
  endtask

  task automatic test_partial_store();
    int lat; logic [31:0] rd; logic er;
    xact2(1'b1, 32'h14, 4'b1111, 32'h11223344, lat, rd, er);
    xact2(1'b1, 32'h14, 4'b0010, 32'h0000AA00, lat, rd, er);
    xact2(1'b0, 32'h14, 4'b0000, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL partial_store got %h required 1122aa44", rd); end
    xact2(1'b1, 32'h14, 4'b0000, 32'hFFFFFFFF, lat, rd, er);
    checks++; if (lat != 3 || er !== 1'b0) begin errors++; $display("FAIL zero_strb_resp got lat=%0d err=%b required 3/0", lat, er); end
    xact2(1'b0, 32'h14, 4'b0000, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL zero_strb_data got %h required 1122aa44", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er;
    xact2(1'b1, 32'h0, 4'b1111, 32'hCAFE0001, lat, rd, er);
    xact2(1'b0, 32'h00001000, 4'b0000, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL oor_load got rd=%h err=%b required 0/1", rd, er); end
    xact2(1'b1, 32'h00001000, 4'b1111, 32'hFFFFFFFF, lat, rd, er);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL oor_store got rd=%h err=%b required 0/1", rd, er); end
    xact2(1'b0, 32'h0, 4'b0000, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hCAFE0001 || er !== 1'b0) begin errors++; $display("FAIL oor_no_write got rd=%h err=%b required cafe0001/0", rd, er); end
  endtask

  task automatic test_stall();
    int n;
    @(negedge clk);
    bus2.resp_ready = 1'b0; bus2.req_valid = 1'b1; bus2.req_write = 1'b0;
    bus2.req_addr = 32'h10; bus2.req_wstrb = 4'b0; bus2.req_wdata = 32'h0;
    n = 0;
    while (bus2.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1; bus2.req_valid = 1'b0;
    n = 0;
    while (bus2.resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n != 2) begin errors++; $display("FAIL stall_latency got %0d edges required 2", n); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus2.resp_valid !== 1'b1 || bus2.resp_rdata !== 32'hDEADBEEF || bus2.resp_err !== 1'b0 ||
          bus2.req_ready !== 1'b0 || busy2 !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b rd=%h err=%b rdy=%b busy=%b required 1/deadbeef/0/0/1",
                 c, bus2.resp_valid, bus2.resp_rdata, bus2.resp_err, bus2.req_ready, busy2);
      end
    end
    bus2.resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus2.resp_valid !== 1'b0 || busy2 !== 1'b0 || bus2.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got v=%b busy=%b rdy=%b required 0/0/1", bus2.resp_valid, busy2, bus2.req_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    int lat, n; logic [31:0] rd; logic er;
    xact2(1'b1, 32'h20, 4'b1111, 32'h55AA55AA, lat, rd, er);
    xact2(1'b0, 32'h20, 4'b0000, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL pre_reset_load got %h required 55aa55aa", rd); end
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_write = 1'b1; bus2.req_addr = 32'h20;
    bus2.req_wstrb = 4'b1111; bus2.req_wdata = 32'h12345678;
    n = 0;
    while (bus2.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1; bus2.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy2 !== 1'b1 || bus2.resp_valid !== 1'b0) begin errors++; $display("FAIL in_wait got busy=%b v=%b required 1/0", busy2, bus2.resp_valid); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus2.req_ready !== 1'b0 || bus2.resp_valid !== 1'b0 || bus2.resp_rdata !== 32'd0 ||
        bus2.resp_err !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got rdy=%b v=%b rd=%h err=%b busy=%b required all 0",
               bus2.req_ready, bus2.resp_valid, bus2.resp_rdata, bus2.resp_err, busy2);
    end
    @(posedge clk); @(negedge clk); rst = 1'b1;
    xact2(1'b0, 32'h20, 4'b0000, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h55AA55AA || er !== 1'b0) begin errors++; $display("FAIL discarded_store got rd=%h err=%b required 55aa55aa/0", rd, er); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    bus0.resp_ready = 1'b1; bus0.req_valid = 1'b1; bus0.req_write = 1'b1;
    bus0.req_addr = 32'h8; bus0.req_wstrb = 4'b1111; bus0.req_wdata = 32'h0A0B0C0D;
    n = 0;
    while (bus0.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    checks++; if (bus0.resp_valid !== 1'b1 || bus0.req_ready !== 1'b0 || bus0.resp_rdata !== 32'd0)
      begin errors++; $display("FAIL b2b_store_resp got v=%b rdy=%b rd=%h required 1/0/0", bus0.resp_valid, bus0.req_ready, bus0.resp_rdata); end
    bus0.req_write = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus0.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1)
      begin errors++; $display("FAIL b2b_gap1 got v=%b rdy=%b required 0/1", bus0.resp_valid, bus0.req_ready); end
    @(posedge clk); #1;
    checks++; if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 32'h0A0B0C0D || bus0.resp_err !== 1'b0)
      begin errors++; $display("FAIL b2b_load_resp got v=%b rd=%h err=%b required 1/0a0b0c0d/0", bus0.resp_valid, bus0.resp_rdata, bus0.resp_err); end
    @(posedge clk); #1;
    checks++; if (bus0.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1)
      begin errors++; $display("FAIL b2b_gap2 got v=%b rdy=%b required 0/1", bus0.resp_valid, bus0.req_ready); end
    bus0.req_valid = 1'b0;
  endtask

  initial begin
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = 32'h0;
    bus2.req_wstrb = 4'h0; bus2.req_wdata = 32'h0; bus2.resp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 32'h0;
    bus0.req_wstrb = 4'h0; bus0.req_wdata = 32'h0; bus0.resp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_partial_store();
    test_out_of_range();
    test_stall();
    test_reset_in_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required finish before 200000", $time);
    $fatal(1);
  end
endmodule
